axi_reg_bank: RTL and testbench

AXI_REG_BANK -- requirements
Module: axi_reg_bank

---
 rtl/axi_reg_bank.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_reg_bank.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_bank.sv
// rtl/axi_reg_bank.sv - AXI4-Lite control/status register bank
//
// Purpose: NUM_CTRL read/write control registers and NUM_STAT read-only status
// registers behind an AXI4-Lite slave. Control i lives at 16'h0000+4i, status i
// at 16'h1000+4i. Only address bits [15:2] are decoded.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   s_axi_aw*/w*/b*       AXI4-Lite write channels (AW and W accepted independently)
//   s_axi_ar*/r*          AXI4-Lite read channels
//   ctrl_regs             current control register values, register i at [32i+31:32i]
//   ctrl_wr_pulse         one-cycle flag per committed control write
//   rst_ctrl_regs         per-register restore to CTRL_DEFAULT
//   status_regs           status register inputs, register i at [32i+31:32i]
//
// Optional feature: define AXI_REG_BANK_WSTRB_EN to honour s_axi_wstrb byte lanes.
module axi_reg_bank #(
    parameter int                       NUM_CTRL     = 8,
    parameter int                       NUM_STAT     = 8,
    parameter logic [NUM_CTRL*32-1:0]   CTRL_DEFAULT = {NUM_CTRL{32'hAABBCCDD}},
    parameter int                       ADDR_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [NUM_CTRL*32-1:0]  ctrl_regs,
    output logic [NUM_CTRL-1:0]     ctrl_wr_pulse,
    input  logic [NUM_CTRL-1:0]     rst_ctrl_regs,
    input  logic [NUM_STAT*32-1:0]  status_regs
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word address a = byte address [15:2]: region in a[13:10], index in a[9:0].
    function automatic logic is_ctrl(input logic [13:0] a);
        return (a[13:10] == 4'h0) && ({22'd0, a[9:0]} < 32'(NUM_CTRL));
    endfunction

    function automatic logic is_stat(input logic [13:0] a);
        return (a[13:10] == 4'h1) && ({22'd0, a[9:0]} < 32'(NUM_STAT));
    endfunction

    // Write channel state
    logic        aw_held_q, aw_held_d;
    logic [13:0] aw_addr_q, aw_addr_d;
    logic        w_held_q,  w_held_d;
    logic [31:0] w_data_q,  w_data_d;
    logic [3:0]  w_strb_q,  w_strb_d;
    logic        awready_q, awready_d;
    logic        wready_q,  wready_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;

    // Read channel state
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;

    // Register storage
    logic [31:0]         ctrl_q [NUM_CTRL];
    logic [31:0]         ctrl_d [NUM_CTRL];
    logic [NUM_CTRL-1:0] pulse_q, pulse_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] wr_word;
    logic        wr_eff;
    logic [13:0] rd_addr;

    assign aw_hs   = s_axi_awvalid && awready_q;
    assign w_hs    = s_axi_wvalid  && wready_q;
    assign ar_hs   = s_axi_arvalid && arready_q;

    // A held beat takes priority over the bus; the bus beat is only used in the
    // cycle it handshakes.
    assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr[15:2];
    assign wr_data = w_held_q  ? w_data_q  : s_axi_wdata;
    assign wr_strb = w_held_q  ? w_strb_q  : s_axi_wstrb;
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign rd_addr = s_axi_araddr[15:2];

    logic unused_addr_bits;
`ifdef AXI_REG_BANK_WSTRB_EN
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:16], s_axi_awaddr[1:0],
                                s_axi_araddr[ADDR_WIDTH-1:16], s_axi_araddr[1:0]};
    assign wr_eff = |wr_strb;
`else
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:16], s_axi_awaddr[1:0],
                                s_axi_araddr[ADDR_WIDTH-1:16], s_axi_araddr[1:0],
                                wr_strb};
    assign wr_eff = 1'b1;
`endif

    // Write channel next state
    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        if (aw_hs) aw_addr_d = s_axi_awaddr[15:2];
        if (w_hs) begin
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bresp_d   = is_ctrl(wr_addr) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            aw_held_d = aw_held_q || aw_hs;
            w_held_d  = w_held_q  || w_hs;
        end
        bvalid_d  = commit || (bvalid_q && !s_axi_bready);
        // Readies are registered from next state so they never follow valids
        // combinationally, and they stay low through the cycle after reset.
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d  && !bvalid_d;
    end

    // Byte-lane merge of the committed write into the addressed register.
    always_comb begin
        wr_word = wr_data;
`ifdef AXI_REG_BANK_WSTRB_EN
        for (int b = 0; b < 4; b++) begin
            if (!wr_strb[b]) wr_word[8*b +: 8] = 8'h00;
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (wr_addr[9:0] == i[9:0]) begin
                for (int b = 0; b < 4; b++) begin
                    if (!wr_strb[b]) wr_word[8*b +: 8] = ctrl_q[i][8*b +: 8];
                end
            end
        end
`endif
    end

    // Control register next state: an AXI write beats a restore on the same edge.
    always_comb begin
        for (int i = 0; i < NUM_CTRL; i++) begin
            ctrl_d[i]  = ctrl_q[i];
            pulse_d[i] = 1'b0;
            if (commit && is_ctrl(wr_addr) && (wr_addr[9:0] == i[9:0])) begin
                ctrl_d[i]  = wr_word;
                pulse_d[i] = wr_eff;
            end else if (rst_ctrl_regs[i]) begin
                ctrl_d[i]  = CTRL_DEFAULT[32*i +: 32];
            end
        end
    end

    // Read channel next state; data is captured from current register values,
    // so a read racing a write commit returns the pre-write value.
    always_comb begin
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = ar_hs || (rvalid_q && !s_axi_rready);
        if (ar_hs) begin
            rdata_d = 32'h0BAD0BAD;
            rresp_d = RESP_SLVERR;
            if (is_ctrl(rd_addr)) begin
                rresp_d = RESP_OKAY;
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (rd_addr[9:0] == i[9:0]) rdata_d = ctrl_q[i];
                end
            end else if (is_stat(rd_addr)) begin
                rresp_d = RESP_OKAY;
                for (int i = 0; i < NUM_STAT; i++) begin
                    if (rd_addr[9:0] == i[9:0]) rdata_d = status_regs[32*i +: 32];
                end
            end
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= CTRL_DEFAULT[32*i +: 32];
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            pulse_q   <= pulse_d;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CTRL; i++) ctrl_regs[32*i +: 32] = ctrl_q[i];
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign ctrl_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axi_reg_bank.sv
// tb/tb_axi_reg_bank.sv - scoreboard bench for axi_reg_bank
module tb_axi_reg_bank;

    localparam int NC = 8;
    localparam int NS = 8;
    localparam logic [31:0] DEF = 32'hAABBCCDD;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     awaddr, wdata, araddr;
    logic            awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]      wstrb;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [31:0]     rdata;
    logic [NC*32-1:0] ctrl_regs;
    logic [NC-1:0]   ctrl_wr_pulse;
    logic [NC-1:0]   rst_ctrl_regs;
    logic [NS*32-1:0] status_regs;

    axi_reg_bank #(.NUM_CTRL(NC), .NUM_STAT(NS), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse),
        .rst_ctrl_regs(rst_ctrl_regs), .status_regs(status_regs)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_ctrl [NC];
    logic [31:0] m_stat [NS];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    int total = 0;
    int bad = 0;

    always_comb begin
        for (int i = 0; i < NS; i++) status_regs[32*i +: 32] = m_stat[i];
    end

    function automatic logic [NC*32-1:0] model_vec();
        logic [NC*32-1:0] v;
        for (int i = 0; i < NC; i++) v[32*i +: 32] = m_ctrl[i];
        return v;
    endfunction

    function automatic int ctrl_index(input logic [31:0] a);
        int off = int'(a[15:0]) & 32'hFFFC;
        if (off < 4*NC) return off / 4;
        return -1;
    endfunction

    function automatic int stat_index(input logic [31:0] a);
        int off = int'(a[15:0]) & 32'hFFFC;
        if (off >= 32'h1000 && off < 32'h1000 + 4*NS) return (off - 32'h1000) / 4;
        return -1;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
`ifdef AXI_REG_BANK_WSTRB_EN
        logic [31:0] m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
`else
        return (s == s) ? d : old;
`endif
    endfunction

    function automatic logic model_eff(input logic [3:0] s);
`ifdef AXI_REG_BANK_WSTRB_EN
        return s != 4'h0;
`else
        return s == s;
`endif
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        int ci = ctrl_index(a);
        int si = stat_index(a);
        if (ci >= 0) return {m_ctrl[ci], 2'b00};
        if (si >= 0) return {m_stat[si], 2'b00};
        return {32'h0BAD0BAD, 2'b10};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (bq.size() == 0) chk("bresp_unexpected", 1, 0);
            else chk("bresp", {254'd0, bresp}, {254'd0, bq.pop_front()});
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) chk("rresp_unexpected", 1, 0);
            else chk("rdata_rresp", {222'd0, rdata, rresp}, {222'd0, rq.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; rst_ctrl_regs = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {253'd0, awready, wready, arready}, 0);
        chk({tag, "_valid"}, {254'd0, bvalid, rvalid}, 0);
        chk({tag, "_resp"}, {220'd0, bresp, rresp, rdata}, 0);
        chk({tag, "_pulse"}, {248'd0, ctrl_wr_pulse}, 0);
        chk({tag, "_ctrl"}, ctrl_regs, {NC{DEF}});
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        check_reset_outputs("reset");
        reset = 0;
        for (int i = 0; i < NC; i++) m_ctrl[i] = DEF;
        step();
        step();
        chk("ready_after_reset", {253'd0, awready, wready, arready}, 3'b111);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [NC-1:0] rmask);
        int ci = ctrl_index(a);
        logic [NC-1:0] exp_pulse = '0;
        logic aw_done = 0, w_done = 0, aw_now, w_now;
        int cyc = 0;
        bq.push_back(ci >= 0 ? 2'b00 : 2'b10);
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done  && (cyc >= w_dly);
            awaddr = a; wdata = d; wstrb = s;
            @(negedge clk);
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            if ((aw_done || aw_now) && (w_done || w_now)) rst_ctrl_regs = rmask;
            step();
            aw_done = aw_done || aw_now;
            w_done  = w_done  || w_now;
            cyc++;
        end
        awvalid = 0; wvalid = 0; rst_ctrl_regs = 0;
        if (!(aw_done && w_done)) chk("write_handshake_timeout", 1, 0);
        for (int i = 0; i < NC; i++) if (rmask[i] && i != ci) m_ctrl[i] = DEF;
        if (ci >= 0) begin
            m_ctrl[ci] = model_merge(m_ctrl[ci], d, s);
            exp_pulse[ci] = model_eff(s);
        end
        chk("bvalid_after_commit", {255'd0, bvalid}, 1);
        chk("ctrl_after_commit", ctrl_regs, model_vec());
        chk("pulse_after_commit", {248'd0, ctrl_wr_pulse}, {248'd0, exp_pulse});
        for (int k = 0; k < b_dly; k++) begin
            step();
            chk("bvalid_hold", {255'd0, bvalid}, 1);
            chk("wr_ready_low_during_b", {254'd0, awready, wready}, 0);
            chk("pulse_once", {248'd0, ctrl_wr_pulse}, 0);
        end
        bready = 1;
        step();
        bready = 0;
        chk("bvalid_drop", {255'd0, bvalid}, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int r_dly);
        logic hs = 0;
        int cyc = 0;
        rq.push_back(model_read(a));
        araddr = a;
        while (!hs && cyc < 20) begin
            arvalid = 1;
            @(negedge clk);
            hs = arready;
            step();
            cyc++;
        end
        arvalid = 0;
        if (!hs) chk("read_handshake_timeout", 1, 0);
        chk("rvalid_after_ar", {255'd0, rvalid}, 1);
        for (int k = 0; k < r_dly; k++) begin
            step();
            chk("rvalid_hold", {254'd0, rvalid, arready}, 2'b10);
        end
        rready = 1;
        step();
        rready = 0;
        chk("rvalid_drop", {255'd0, rvalid}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w, a, d;
        logic [NC-1:0] rm;
        int hs_cnt;
        for (int i = 0; i < NS; i++) m_stat[i] = $urandom;
        for (int i = 0; i < NC; i++) m_ctrl[i] = DEF;
        do_reset();

        // Strobe behaviour on default ctrl0
`ifdef AXI_REG_BANK_WSTRB_EN
        exp_w = 32'hAA22CC44;
`else
        exp_w = 32'h11223344;
`endif
        do_write(32'h0000, 32'h11223344, 4'b0101, 0, 0, 0, '0);
        chk("wstrb_ctrl0", {224'd0, ctrl_regs[31:0]}, {224'd0, exp_w});

        // Same-cycle AW/W to control 1
        do_write(32'h0004, 32'h12345678, 4'hF, 0, 0, 0, '0);
        chk("ctrl1_value", {224'd0, ctrl_regs[63:32]}, {224'd0, 32'h12345678});

        // W three cycles before AW, bready held low
        do_write(32'h0000, 32'hCAFEF00D, 4'hF, 3, 0, 4, '0);

        // Error writes and unmapped read
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0, 1, 0, '0);
        do_write(32'h0FFC, 32'hFFFFFFFF, 4'hF, 1, 0, 0, '0);
        do_read(32'h2000, 2);
        do_read(32'h1004, 0);
        do_read(32'h0004, 1);

        // Restore racing a write, then restore alone
        do_write(32'h0008, 32'h55AA55AA, 4'hF, 0, 0, 0, 8'h04);
        chk("write_beats_restore", {224'd0, ctrl_regs[95:64]}, {224'd0, 32'h55AA55AA});
        rst_ctrl_regs = 8'h04;
        step();
        rst_ctrl_regs = 0;
        m_ctrl[2] = DEF;
        chk("restore_alone", {224'd0, ctrl_regs[95:64]}, {224'd0, DEF});

        // Read of control 1 on the same edge as a write to it: pre-write value
        chk("idle_readies", {253'd0, awready, wready, arready}, 3'b111);
        rq.push_back({m_ctrl[1], 2'b00});
        bq.push_back(2'b00);
        awaddr = 32'h4; wdata = 32'h0F0F1234; wstrb = 4'hF; araddr = 32'h4;
        awvalid = 1; wvalid = 1; arvalid = 1;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        m_ctrl[1] = model_merge(m_ctrl[1], 32'h0F0F1234, 4'hF);
        chk("concurrent_valids", {254'd0, bvalid, rvalid}, 2'b11);
        chk("concurrent_ctrl", ctrl_regs, model_vec());
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;

        // Reset between AW and W: the held address must be discarded
        awaddr = 32'h000C; awvalid = 1;
        hs_cnt = 0;
        for (int c = 0; c < 10 && hs_cnt == 0; c++) begin
            @(negedge clk);
            if (awready) hs_cnt = 1;
            step();
        end
        awvalid = 0;
        reset = 1;
        step();
        check_reset_outputs("mid_txn_reset");
        reset = 0;
        for (int i = 0; i < NC; i++) m_ctrl[i] = DEF;
        step();
        wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        step();
        wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_commit_after_reset", {255'd0, bvalid}, 0);
        end
        chk("ctrl_untouched_after_reset", ctrl_regs, model_vec());
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: a = ($urandom & 32'hFFFF0000) | (32'($urandom_range(0, NC-1)) * 4) | 32'($urandom_range(0, 3));
                1: a = 32'h1000 + 32'($urandom_range(0, NS-1)) * 4;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                rm = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2), rm);
            end else begin
                do_read(a, $urandom_range(0, 2));
            end
        end

        step();
        chk("scoreboard_drained", {192'd0, 32'(bq.size()), 32'(rq.size())}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
